// File: rtl/pc_fetch.sv
// Program counter and sequential instruction fetch for miniRV, buffering {pc, inst} in a 2-entry queue.
// Single outstanding request; an entry is visible the cycle after its response, and fetch stalls while the queue is full.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        advance_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] pc_buf_q [2];
  logic [31:0] pc_buf_d [2];
  logic [31:0] inst_buf_q [2];
  logic [31:0] inst_buf_d [2];

  logic req, push, pop;
  logic unused_npc;

  assign unused_npc = ^npc_i[1:0];

  // Reset gates the request so the port reads 0 while rst_i is held.
  assign req  = !rst_i && (state_q == S_IDLE) && (count_q < 2'd2) && !redirect_i;
  assign push = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop  = advance_i && (count_q != 2'd0) && !redirect_i;

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = (count_q != 2'd0);
  assign pc_o         = inst_valid_o ? pc_buf_q[rd_ptr_q] : 32'h0;
  assign inst_o       = inst_valid_o ? inst_buf_q[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_buf_d   = pc_buf_q;
    inst_buf_d = inst_buf_q;

    case (state_q)
      S_IDLE:    if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid_i)   state_d = S_IDLE;
        else if (redirect_i) state_d = S_DISCARD;
      end
      S_DISCARD: if (imem_rvalid_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_i) begin
      // Realign both pointers on flush so the next push lands at the head.
      fetch_pc_d = {npc_i[31:2], 2'b00};
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end else begin
      if (push) begin
        pc_buf_d[wr_ptr_q]   = req_pc_q;
        inst_buf_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= 32'h0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      pc_buf_q[0]   <= 32'h0;
      pc_buf_q[1]   <= 32'h0;
      inst_buf_q[0] <= 32'h0;
      inst_buf_q[1] <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_buf_q   <= pc_buf_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: cycle table, directed corner sequences and randomized traffic against a queue-based model.
module tb_pc_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] npc_i;
  logic        redirect_i;
  logic        advance_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .npc_i(npc_i), .redirect_i(redirect_i),
    .advance_i(advance_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .pc_o(pc_o), .inst_o(inst_o)
  );

  always #5 clk_i = ~clk_i;

  int total, bad;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          m_out, m_keep;
  logic [31:0] m_fpc, m_rpc;

  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat;
  bit          rand_lat, spur_en;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_out    = 0;
    m_keep   = 0;
    m_fpc    = 32'h0;
    m_rpc    = 32'h0;
    mem_pend = 0;
    mem_cnt  = 0;
  endtask

  // One clock cycle: drive memory, sample and check outputs, then advance model and memory.
  task automatic step();
    bit   resp_now, m_req, push, do_pop;
    int   size_pre;
    resp_now = mem_pend && (mem_cnt == 1);
    if (resp_now) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(mem_addr);
    end else if (spur_en && !mem_pend && ($urandom_range(0, 7) == 0)) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    m_req = !m_out && (mq.size() < 2) && !redirect_i;
    chk("req", imem_req_o, m_req);
    chk("addr", imem_addr_o, m_fpc);
    chk("valid", inst_valid_o, mq.size() != 0);
    chk("pc", pc_o, mq.size() != 0 ? mq[0].pc : 32'h0);
    chk("inst", inst_o, mq.size() != 0 ? mq[0].inst : 32'h0);
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = inst_valid_o;
    s_pc = pc_o; s_inst = inst_o;
    @(posedge clk_i);
    size_pre = mq.size();
    if (redirect_i) begin
      mq.delete();
      m_fpc = {npc_i[31:2], 2'b00};
      if (m_out && imem_rvalid_i) m_out = 0;
      else if (m_out)             m_keep = 0;
    end else begin
      push   = 0;
      do_pop = advance_i && (size_pre > 0);
      if (m_out && imem_rvalid_i) begin
        push  = m_keep;
        m_out = 0;
      end
      if (push) chk("no_overflow", size_pre < 2, 1);
      if (do_pop) void'(mq.pop_front());
      if (push) mq.push_back('{pc: m_rpc, inst: imem_rdata_i});
      if (m_req) begin
        m_out  = 1;
        m_keep = 1;
        m_rpc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
    end
    if (resp_now)      mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (s_req) begin
      mem_pend = 1;
      mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_addr = s_addr;
    end
    @(negedge clk_i);
  endtask

  task automatic run_until_req(input int maxc, input string nm);
    bit got = 0;
    for (int k = 0; k < maxc && !got; k++) begin
      step();
      got = s_req;
    end
    chk({nm, "_req_seen"}, got, 1);
  endtask

  task automatic run_until_valid(input int maxc, input string nm);
    bit got = 0;
    for (int k = 0; k < maxc && !got; k++) begin
      step();
      got = s_valid;
    end
    chk({nm, "_valid_seen"}, got, 1);
  endtask

  typedef struct {
    logic        adv;
    logic        rq;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int          nreq;
    logic [31:0] raddr[2];
    bit          found;

    total = 0; bad = 0;
    lat = 1; rand_lat = 0; spur_en = 0;
    rst_i = 1'b1; redirect_i = 1'b0; advance_i = 1'b0; npc_i = 32'h0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    m_reset();

    // Latency 1, advance held: requests two cycles apart, head follows.
    tbl[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      advance_i = tbl[i].adv;
      step();
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].rq);
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_inst", i), s_inst, tbl[i].vld ? mem_data(tbl[i].pc) : 32'h0);
    end

    // Latency 2, no advance: two requests then stall with the queue full.
    rst_i = 1'b1; advance_i = 1'b0; m_reset(); lat = 2;
    @(negedge clk_i);
    rst_i = 1'b0;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (s_req) begin
        if (nreq < 2) raddr[nreq] = s_addr;
        nreq++;
      end
    end
    chk("full_nreq", nreq, 2);
    chk("full_addr0", raddr[0], 32'h0);
    chk("full_addr1", raddr[1], 32'h4);
    chk("full_req_idle", s_req, 0);
    chk("full_head", s_pc, 32'h0);
    advance_i = 1'b1;
    step();
    advance_i = 1'b0;
    lat = 3;
    step();
    chk("adv_req", s_req, 1);
    chk("adv_addr", s_addr, 32'h8);

    // Redirect while 0x8 is outstanding: its response is discarded.
    redirect_i = 1'b1; npc_i = 32'h0000_1002;
    step();
    redirect_i = 1'b0;
    step();
    chk("redir_flush_valid", s_valid, 0);
    run_until_req(10, "redir");
    chk("redir_addr", s_addr, 32'h1000);
    run_until_valid(10, "redir");
    chk("redir_pc", s_pc, 32'h1000);
    chk("redir_inst", s_inst, mem_data(32'h1000));

    // Redirect coinciding with the response in WAIT.
    lat = 1; advance_i = 1'b1;
    run_until_req(20, "same");
    redirect_i = 1'b1; npc_i = 32'h0000_2000; advance_i = 1'b0;
    step();
    redirect_i = 1'b0;
    step();
    chk("same_req", s_req, 1);
    chk("same_addr", s_addr, 32'h2000);

    // Count 1: push and pop in the same cycle.
    step();
    step();
    chk("pp_pre_pc", s_pc, 32'h2000);
    chk("pp_pre_req", s_req, 1);
    advance_i = 1'b1;
    step();
    advance_i = 1'b0;
    step();
    chk("pp_valid", s_valid, 1);
    chk("pp_pc", s_pc, 32'h2004);
    chk("pp_inst", s_inst, mem_data(32'h2004));

    // Fetch PC wraps past the top of the address space.
    advance_i = 1'b1;
    redirect_i = 1'b1; npc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    run_until_req(10, "wrap1");
    chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    run_until_req(10, "wrap2");
    chk("wrap_addr_zero", s_addr, 32'h0);

    // Asynchronous reset in WAIT with a valid entry.
    redirect_i = 1'b1; npc_i = 32'h0000_0400; lat = 3;
    step();
    redirect_i = 1'b0; advance_i = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = s_valid && s_req;
    end
    chk("arst_setup", found, 1);
    #1;
    chk("arst_pre_valid", inst_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_req", imem_req_o, 0);
    chk("arst_addr", imem_addr_o, 32'h0);
    chk("arst_valid", inst_valid_o, 0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_inst", inst_o, 32'h0);
    m_reset();
    imem_rvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    step();
    chk("arst_first_req", s_req, 1);
    chk("arst_first_addr", s_addr, 32'h0);

    // Randomized traffic with variable latency, spurious idle responses and redirects.
    rand_lat = 1; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      advance_i  = 1'($urandom_range(0, 1));
      redirect_i = ($urandom_range(0, 11) == 0);
      npc_i      = $urandom;
      step();
    end
    redirect_i = 1'b0; advance_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
